root_dispatch: RTL

ROOT_DISPATCH -- requirements
Module: root_dispatch

---
 rtl/root_dispatch.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/root_dispatch.sv
// Root-engine request dispatcher: queues radicand/degree requests, issues them one
// at a time to the engine and returns tagged responses. Optional WAIT watchdog: ROOT_DISPATCH_TIMEOUT_EN.
module root_dispatch #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [9:0]  req_radicand,
    input  logic [2:0]  req_degree,
    output logic        eng_in_valid,
    output logic [9:0]  eng_in_data_1,
    output logic [2:0]  eng_in_data_2,
    input  logic        eng_out_valid,
    input  logic [19:0] eng_out_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [19:0] rsp_data,
    output logic [1:0]  rsp_tag,
    output logic        rsp_err,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 15;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state, state_next;
    logic [EW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           full, empty, push, pop;
    logic [EW-1:0]  head;
    logic [1:0]     tag;
    logic [9:0]     op_radicand;
    logic [2:0]     op_degree;
    logic [1:0]     op_tag;
    logic [19:0]    result;
    logic           err;
    logic           load_ok, load_err;

`ifdef ROOT_DISPATCH_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TW-1:0]  wd_cnt;
`endif

    // Entry layout: {radicand[14:5], degree[4:2], tag[1:0]}
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign head      = mem[rd_ptr];

    assign rsp_valid = (state == RESP);
    assign rsp_data  = result;
    assign rsp_err   = err;
    assign rsp_tag   = op_tag;
    assign busy      = (state != IDLE) || !empty;

    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        load_ok       = 1'b0;
        load_err      = 1'b0;
        eng_in_valid  = 1'b0;
        eng_in_data_1 = '0;
        eng_in_data_2 = '0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head[4:2] == 3'd0) begin
                        load_err   = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                eng_in_valid  = 1'b1;
                eng_in_data_1 = op_radicand;
                eng_in_data_2 = op_degree;
                state_next    = WAIT;
            end
            WAIT: begin
                // A result arriving on the watchdog's last cycle still wins.
                if (eng_out_valid) begin
                    load_ok    = 1'b1;
                    state_next = RESP;
                end
`ifdef ROOT_DISPATCH_TIMEOUT_EN
                else if (wd_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    load_err   = 1'b1;
                    state_next = RESP;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {req_radicand, req_degree, tag};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tag         <= '0;
            op_radicand <= '0;
            op_degree   <= '0;
            op_tag      <= '0;
            result      <= '0;
            err         <= 1'b0;
        end else begin
            state <= state_next;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                tag    <= tag + 2'd1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + AW'(1);
                op_radicand <= head[14:5];
                op_degree   <= head[4:2];
                op_tag      <= head[1:0];
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (load_ok) begin
                result <= eng_out_data;
                err    <= 1'b0;
            end else if (load_err) begin
                result <= '0;
                err    <= 1'b1;
            end
        end
    end

`ifdef ROOT_DISPATCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)              wd_cnt <= '0;
        else if (state == ISSUE) wd_cnt <= '0;
        else if (state == WAIT)  wd_cnt <= wd_cnt + TW'(1);
    end
`endif

endmodule
